// File: rtl/pe_prec_sequencer.sv
// pe_prec_sequencer: walks the (weight slice, activation slice) pairs of a
// multi-precision dot product through a 2-bit-slice PE. It drives one pair per
// cycle and accumulates the PE partial sums, each shifted by 2*(i+j).
module pe_prec_sequencer #(
    parameter int unsigned LANES    = 4,
    parameter int unsigned SLICE    = 2,
    parameter int unsigned MAX_PREC = 8,
    parameter int unsigned PSUM_W   = 8,
    parameter int unsigned ACC_W    = 24
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic                      i_start,
    output logic                      o_ready,
    input  logic [1:0]                i_act_prec,
    input  logic [1:0]                i_wgt_prec,
    input  logic                      i_act_signed,
    input  logic                      i_wgt_signed,
    input  logic [LANES*MAX_PREC-1:0] i_act,
    input  logic [LANES*MAX_PREC-1:0] i_wgt,
    output logic [LANES*SLICE-1:0]    o_pe_act,
    output logic [LANES*SLICE-1:0]    o_pe_wgt,
    output logic                      o_pe_signI,
    output logic                      o_pe_signW,
    input  logic [PSUM_W-1:0]         i_pe_psum,
    output logic [ACC_W-1:0]          o_result,
    output logic                      o_valid,
    input  logic                      i_out_ready,
    output logic                      o_err
);

    localparam int unsigned OP_W    = LANES * MAX_PREC;
    localparam int unsigned PE_W    = LANES * SLICE;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned SHIFT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Precision code to (slice count - 1); 11 is rejected before this is used.
    function automatic logic [IDX_W-1:0] slices_m1(input logic [1:0] prec);
        case (prec)
            2'b00:   slices_m1 = 2'd0;
            2'b01:   slices_m1 = 2'd1;
            default: slices_m1 = 2'd3;
        endcase
    endfunction

    state_t               state, state_d;

    logic [OP_W-1:0]      act_q, wgt_q;
    logic [IDX_W-1:0]     na_m1, nw_m1;
    logic                 act_sgn, wgt_sgn;
    logic [IDX_W-1:0]     i_q, j_q;
    logic                 iss_vld, cap_vld;
    logic [SHIFT_W-1:0]   iss_shift, cap_shift;
    logic [ACC_W-1:0]     acc;

    logic                 legal, accept, last_pair;
    logic [ACC_W-1:0]     psum_ext, acc_add;

    logic [OP_W-1:0]      src_act, src_wgt;
    logic [IDX_W-1:0]     src_na_m1, src_nw_m1;
    logic                 src_as, src_ws;
    logic [IDX_W-1:0]     i_sel, j_sel, i_d, j_d;
    logic                 pair_en;
    logic [PE_W-1:0]      pe_act_d, pe_wgt_d;
    logic                 pe_signI_d, pe_signW_d;
    logic [SHIFT_W-1:0]   iss_shift_d;
    logic [ACC_W-1:0]     acc_d, result_d;
    logic                 valid_d, ready_d, err_d;

    assign legal     = (i_act_prec != 2'b11) && (i_wgt_prec != 2'b11);
    assign accept    = (state == IDLE) && i_start && legal;
    assign last_pair = (i_q == nw_m1) && (j_q == na_m1);

    // Sign-extended PE partial sum folded into the accumulator at its weight.
    assign psum_ext = ACC_W'($signed(i_pe_psum));
    assign acc_add  = cap_vld ? (acc + (psum_ext << cap_shift)) : acc;

    // State register
    always_ff @(posedge CLK) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept)      state_d = ISSUE;
            ISSUE:   if (last_pair)   state_d = DRAIN;
            DRAIN:                    state_d = DONE;
            DONE:    if (i_out_ready) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Output/datapath next values: the pair to put on the PE bus next cycle
    always_comb begin
        src_act     = act_q;
        src_wgt     = wgt_q;
        src_na_m1   = na_m1;
        src_nw_m1   = nw_m1;
        src_as      = act_sgn;
        src_ws      = wgt_sgn;
        i_sel       = '0;
        j_sel       = '0;
        pair_en     = 1'b0;
        pe_act_d    = '0;
        pe_wgt_d    = '0;
        pe_signI_d  = 1'b0;
        pe_signW_d  = 1'b0;
        iss_shift_d = '0;

        if (state == IDLE) begin
            // First pair comes straight from the inputs on the accept cycle.
            src_act   = i_act;
            src_wgt   = i_wgt;
            src_na_m1 = slices_m1(i_act_prec);
            src_nw_m1 = slices_m1(i_wgt_prec);
            src_as    = i_act_signed;
            src_ws    = i_wgt_signed;
            pair_en   = accept;
        end else if (state == ISSUE) begin
            pair_en = !last_pair;
            if (j_q == na_m1) begin
                i_sel = i_q + 2'd1;
                j_sel = '0;
            end else begin
                i_sel = i_q;
                j_sel = j_q + 2'd1;
            end
        end

        if (pair_en) begin
            for (int k = 0; k < int'(LANES); k++) begin
                pe_act_d[k*SLICE +: SLICE] = src_act[k*MAX_PREC + int'(j_sel)*SLICE +: SLICE];
                pe_wgt_d[k*SLICE +: SLICE] = src_wgt[k*MAX_PREC + int'(i_sel)*SLICE +: SLICE];
            end
            pe_signI_d  = src_as && (j_sel == src_na_m1);
            pe_signW_d  = src_ws && (i_sel == src_nw_m1);
            iss_shift_d = ({2'b00, i_sel} + {2'b00, j_sel}) << 1;
        end

        i_d      = pair_en ? i_sel : i_q;
        j_d      = pair_en ? j_sel : j_q;
        acc_d    = accept ? '0 : acc_add;
        result_d = (state == DRAIN) ? acc_add : o_result;
        valid_d  = (state_d == DONE);
        ready_d  = (state_d == IDLE);
        err_d    = (state == IDLE) && i_start && !legal;
    end

    // Registered outputs, issue/capture pipeline and operand latches
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            act_q      <= '0;
            wgt_q      <= '0;
            na_m1      <= '0;
            nw_m1      <= '0;
            act_sgn    <= 1'b0;
            wgt_sgn    <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            iss_vld    <= 1'b0;
            iss_shift  <= '0;
            cap_vld    <= 1'b0;
            cap_shift  <= '0;
            acc        <= '0;
            o_pe_act   <= '0;
            o_pe_wgt   <= '0;
            o_pe_signI <= 1'b0;
            o_pe_signW <= 1'b0;
            o_result   <= '0;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
            o_err      <= 1'b0;
        end else begin
            if (accept) begin
                act_q   <= i_act;
                wgt_q   <= i_wgt;
                na_m1   <= slices_m1(i_act_prec);
                nw_m1   <= slices_m1(i_wgt_prec);
                act_sgn <= i_act_signed;
                wgt_sgn <= i_wgt_signed;
            end
            i_q        <= i_d;
            j_q        <= j_d;
            iss_vld    <= pair_en;
            iss_shift  <= iss_shift_d;
            cap_vld    <= iss_vld;
            cap_shift  <= iss_shift;
            acc        <= acc_d;
            o_pe_act   <= pe_act_d;
            o_pe_wgt   <= pe_wgt_d;
            o_pe_signI <= pe_signI_d;
            o_pe_signW <= pe_signW_d;
            o_result   <= result_d;
            o_valid    <= valid_d;
            o_ready    <= ready_d;
            o_err      <= err_d;
        end
    end

endmodule

// File: doc/pe_prec_sequencer.md
Name: pe_prec_sequencer

Overview:
Sequences one 2-bit-slice PE (sip_dot, sip_dot_adder and the one-cycle DFFQ output register) to compute a multi-precision dot product of LANES activation/weight pairs. Each operand can be 2, 4 or 8 bits, signed or unsigned. The block decomposes each operand into 2-bit slices and issues every (weight slice, activation slice) pair to the PE, one pair per cycle, driving the PE sign flags on MSB slices. It accumulates the returned partial sums shifted by 2*(i+j) and hands the result out over a valid/ready interface. It sits between the layer controller and each PE.

Parameters:
LANES, 4, activation/weight pairs per dot product (PE input width = LANES*SLICE)
SLICE, 2, bits per slice; fixed by the PE
MAX_PREC, 8, maximum operand precision; lane field width
PSUM_W, 8, PE output width (`BITS_SIP_DOT_ADDER), signed
ACC_W, 24, accumulator/result width, signed

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  synchronous active-low reset
i_start  in  1  request new job; accepted when i_start && o_ready
o_ready  out  1  high only in IDLE
i_act_prec  in  2  00=2b, 01=4b, 10=8b, 11=illegal
i_wgt_prec  in  2  same encoding
i_act_signed  in  1  activations are two's complement
i_wgt_signed  in  1  weights are two's complement
i_act  in  LANES*MAX_PREC  lane k = bits [k*8 +: 8]; value in the low prec bits
i_wgt  in  LANES*MAX_PREC  same packing
o_pe_act  out  LANES*SLICE  to PE Input_Feature; lane k slot [k*2 +: 2]
o_pe_wgt  out  LANES*SLICE  to PE Weight
o_pe_signI  out  1  to PE i_SignI
o_pe_signW  out  1  to PE i_SignW
i_pe_psum  in  PSUM_W  from PE Output_PSUM, signed
o_result  out  ACC_W  signed dot product
o_valid  out  1  result valid
i_out_ready  in  1  consumer accepts the result
o_err  out  1  one-cycle pulse when a start is rejected for an illegal precision

Behaviour:
- Reset (RESETn low at a rising edge) forces the following, regardless of state, including mid-job:
  - state IDLE
  - o_ready=1, o_valid=0, o_err=0, o_result=0
  - o_pe_act, o_pe_wgt, o_pe_signI and o_pe_signW all 0
  - accumulator and capture pipeline bit cleared
  - No stale PE output is accumulated after reset.
- Slice counts: Na = 1, 2 or 4 activation slices; Nw likewise for weights; N = Na*Nw.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE, start accepted with both precisions legal: latch operands, precisions and sign flags; clear accumulator; set i=0, j=0; go to ISSUE. The accept cycle is cycle 0.
  - IDLE, start with either precision = 11: stay in IDLE, pulse o_err for one cycle, latch nothing.
  - ISSUE (cycles 1..N), one pair per cycle:
    - o_pe_act lane k = act lane k bits [2j +: 2].
    - o_pe_wgt lane k = wgt lane k bits [2i +: 2].
    - o_pe_signI = act_signed && (j == Na-1).
    - o_pe_signW = wgt_signed && (i == Nw-1).
    - j is the inner loop: it increments each cycle and wraps to 0, at which point i increments.
    - After issuing pair (Nw-1, Na-1), go to DRAIN.
    - The shift amount 2*(i+j) and a valid bit are registered alongside each issue.
  - Capture: in any cycle where the registered valid bit is 1, acc += sign_extend(i_pe_psum) << shift. Captures occur in cycles 2..N+1.
  - DRAIN (cycle N+1): PE outputs are 0; perform the last capture; go to DONE.
  - DONE: o_valid=1 with o_result = acc, both held stable until i_out_ready=1. On that handshake cycle go to IDLE; o_valid drops next cycle.
- Latency: o_valid first high in cycle N+2. Minimum start-to-start spacing is N+3 cycles with i_out_ready tied high.
- i_start outside IDLE is ignored and never queued. Operand inputs are sampled only on the accept cycle.
- Outside ISSUE, PE drive outputs are 0, so the PE settles to psum 0.
- Arithmetic:
  - psum is always treated as signed.
  - Largest shift is 12 (8b x 8b).
  - ACC_W=24 cannot overflow for LANES<=4; no saturation logic.
- Unused high bits of lane fields (bits >= prec) are ignored.

Test Plan:
- 2b x 2b unsigned: act lanes {3,2,1,0}, wgt lanes {3,3,3,3} -> o_result=18; o_valid rises in cycle 3; exactly 1 issue cycle.
- 4b x 4b unsigned: all act lanes 15, all wgt lanes 15 -> o_result=900; issue order (i,j) = (0,0),(0,1),(1,0),(1,1) with signI/signW=0; o_valid in cycle 6.
- 8b x 8b signed: act {-1,100,-128,5}, wgt {2,-3,127,0} -> o_result=-16558 (0xFFBF52); signI high when j=3; signW high when i=3; o_valid in cycle 18.
- 8b signed act x 2b unsigned wgt: act {-128,-1,127,1}, wgt {3,3,3,3} -> o_result=-3; signW never high.
- Backpressure and illegal start:
  - i_out_ready low for 5 cycles in DONE -> o_result and o_valid stay stable; o_ready=0; an i_start pulse during this time is ignored.
  - i_act_prec=11 with i_start in IDLE -> o_err high for one cycle; o_ready stays 1.
- Reset mid-job: assert RESETn=0 in ISSUE cycle 3 of an 8b x 8b job -> next cycle IDLE, o_valid=0, PE drives 0. A following 2b x 2b job still yields its correct result (18 for the first vector).
